// File: rtl/tape_block_loader.sv
// Tape block loader: assembles MSB-first bits into bytes, keeps the first byte as the flag
// and writes the rest to memory. Checksum checking is built in only with TAPE_LOADER_CHECKSUM_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | disarmed, waiting for arm
// WAIT_SYNC | armed, waiting for pilot/sync
// RECV      | shifting bits in, timeout counter running
// WRITE     | memory write request held until ack
// CHECK     | end of block decision (partial byte / checksum)
// DONE      | block loaded, held until arm drops
// ERROR     | load failed, err_code valid, held until arm drops
module tape_block_loader #(
    parameter int TIMEOUT_TICKS = 54000,
    parameter int ADDR_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              sync_detected,
    input  logic              bit_valid,
    input  logic              bit_data,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] max_len,
    output logic              reader_start,
    output logic              mem_wr_req,
    input  logic              mem_wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [7:0]        flag_byte,
    output logic [ADDR_W-1:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_SYNC, S_RECV, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_TICKS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        w_err_next;
    logic [1:0]        r_err_code;
    logic              r_start;
    logic [TW-1:0]     r_timer;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_max_len;
    logic [ADDR_W-1:0] r_byte_count;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [6:0]        r_shift;
    logic [2:0]        r_bitcnt;
    logic              r_flag_seen;
    logic [7:0]        r_flag_byte;

    logic              w_bit_in;
    logic [7:0]        w_byte;
    logic              w_byte_done;
    logic              w_timeout;
    logic              w_arm_start;
    logic              w_csum_ok;

    assign w_bit_in    = bit_valid && (r_state == S_RECV || r_state == S_WRITE);
    assign w_byte      = {r_shift, bit_data};
    assign w_byte_done = w_bit_in && (r_bitcnt == 3'd7);
    assign w_timeout   = (r_state == S_RECV) && !bit_valid && (r_timer == '0);
    assign w_arm_start = (r_state == S_IDLE) && arm;

`ifdef TAPE_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_csum <= 8'd0;
        else if (w_arm_start)
            r_csum <= 8'd0;
        else if (w_byte_done)
            r_csum <= r_csum ^ w_byte;
    end

    assign w_csum_ok = (r_csum == 8'd0);
`else
    assign w_csum_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err_code;
        case (r_state)
            S_IDLE: begin
                w_err_next = 2'd0;
                if (arm)
                    w_state_next = S_WAIT_SYNC;
            end
            S_WAIT_SYNC: begin
                if (sync_detected)
                    w_state_next = S_RECV;
            end
            S_RECV: begin
                if (w_byte_done) begin
                    if (r_flag_seen) begin
                        if (r_byte_count == r_max_len) begin
                            w_state_next = S_ERROR;
                            w_err_next   = 2'd3;
                        end else begin
                            w_state_next = S_WRITE;
                        end
                    end
                end else if (w_timeout) begin
                    w_state_next = S_CHECK;
                end
            end
            S_WRITE: begin
                if (w_byte_done) begin
                    w_state_next = S_ERROR;
                    w_err_next   = 2'd2;
                end else if (mem_wr_ack) begin
                    w_state_next = S_RECV;
                end
            end
            S_CHECK: begin
                if (r_bitcnt != 3'd0) begin
                    w_state_next = S_ERROR;
                    w_err_next   = 2'd1;
                end else if (!r_flag_seen) begin
                    w_state_next = S_WAIT_SYNC;
                end else if (w_csum_ok) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_ERROR;
                    w_err_next   = 2'd3;
                end
            end
            S_DONE, S_ERROR: ;
            default: w_state_next = S_IDLE;
        endcase
        if (!arm) begin
            w_state_next = S_IDLE;
            w_err_next   = 2'd0;
        end
    end

    always_comb begin
        busy         = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
        done         = (r_state == S_DONE);
        error        = (r_state == S_ERROR);
        mem_wr_req   = (r_state == S_WRITE);
        reader_start = r_start;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        err_code     = r_err_code;
        flag_byte    = r_flag_byte;
        byte_count   = r_byte_count;
    end

    // Timer is a down-counter held at its load value outside RECV, so entry to RECV restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start      <= 1'b0;
            r_err_code   <= 2'd0;
            r_timer      <= '0;
            r_base       <= '0;
            r_max_len    <= '0;
            r_byte_count <= '0;
            r_addr       <= '0;
            r_wdata      <= 8'd0;
            r_shift      <= 7'd0;
            r_bitcnt     <= 3'd0;
            r_flag_seen  <= 1'b0;
            r_flag_byte  <= 8'd0;
        end else begin
            r_start    <= (r_state == S_WAIT_SYNC) && (w_state_next == S_RECV);
            r_err_code <= w_err_next;

            if (r_state != S_RECV || bit_valid)
                r_timer <= TO_LOAD;
            else if (r_timer != '0)
                r_timer <= r_timer - TW'(1);

            if (w_arm_start) begin
                r_base       <= base_addr;
                r_max_len    <= max_len;
                r_byte_count <= '0;
                r_bitcnt     <= 3'd0;
                r_flag_seen  <= 1'b0;
                r_flag_byte  <= 8'd0;
            end

            if (w_bit_in) begin
                r_shift  <= w_byte[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            if (w_byte_done && r_state == S_RECV) begin
                if (!r_flag_seen) begin
                    r_flag_byte <= w_byte;
                    r_flag_seen <= 1'b1;
                end else begin
                    r_addr  <= r_base + r_byte_count;
                    r_wdata <= w_byte;
                end
            end

            if (r_state == S_WRITE && w_state_next == S_RECV)
                r_byte_count <= r_byte_count + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_tape_block_loader.sv
// Self-checking bench for tape_block_loader: directed scenarios plus randomized blocks
// checked against a block-level model (flag, writes, count, outcome).
module tb_tape_block_loader;

    localparam int TO = 40;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset, arm, sync_detected, bit_valid, bit_data, mem_wr_ack;
    logic [AW-1:0] base_addr, max_len, mem_addr, byte_count;
    logic          reader_start, mem_wr_req, busy, done, error;
    logic [7:0]    mem_wdata, flag_byte;
    logic [1:0]    err_code;

    int tests = 0;
    int fails = 0;

    bit ack_en = 1'b1;
    int ack_delay = 0;
    int ack_wait = 0;

    logic [AW+7:0] wr_log[$];
    int            stab_viol = 0;
    logic          p_req = 1'b0, p_ack = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [7:0]    p_data = '0;

    logic [7:0]    blk[$];
    logic [AW+7:0] exp_w[$];
    int            exp_count;
    int            exp_err;

    tape_block_loader #(.TIMEOUT_TICKS(TO), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .sync_detected(sync_detected),
        .bit_valid(bit_valid), .bit_data(bit_data), .base_addr(base_addr),
        .max_len(max_len), .reader_start(reader_start), .mem_wr_req(mem_wr_req),
        .mem_wr_ack(mem_wr_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .flag_byte(flag_byte), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Memory responder: acks a pending request after ack_delay further cycles.
    initial begin
        mem_wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_wr_ack = 1'b0;
            if (ack_en && mem_wr_req) begin
                if (ack_wait >= ack_delay) begin
                    mem_wr_ack = 1'b1;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_wr_req && p_req && !p_ack && (mem_addr !== p_addr || mem_wdata !== p_data))
            stab_viol++;
        if (mem_wr_req && mem_wr_ack)
            wr_log.push_back({mem_addr, mem_wdata});
        p_req  <= mem_wr_req;
        p_ack  <= mem_wr_ack;
        p_addr <= mem_addr;
        p_data <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input int gap);
        for (int i = 7; i > 7 - nbits; i--) begin
            bit_valid = 1'b1;
            bit_data  = b[i];
            tick();
            bit_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic arm_and_sync(input logic [AW-1:0] base, input logic [AW-1:0] ml);
        base_addr = base;
        max_len   = ml;
        arm       = 1'b1;
        tick();
        sync_detected = 1'b1;
        tick();
        sync_detected = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int n);
        n = 0;
        while (!(done || error) && n < budget) begin
            tick();
            n++;
        end
        if (!(done || error)) begin
            tests++;
            fails++;
            $display("FAIL wait_end: no done/error after %0d cycles", budget);
        end
    endtask

    task automatic disarm();
        arm = 1'b0;
        tick();
        tick();
    endtask

    // Block-level expectation: flag is blk[0], data bytes follow, writes capped at max_len.
    task automatic model_block(input logic [AW-1:0] base, input logic [AW-1:0] ml);
        logic [7:0]    x;
        logic [AW-1:0] a;
        int            nd, nw;
        x = 8'd0;
        foreach (blk[i]) x ^= blk[i];
        nd = blk.size() - 1;
        nw = (nd > int'(ml)) ? int'(ml) : nd;
        exp_w.delete();
        for (int i = 0; i < nw; i++) begin
            a = base + AW'(i);
            exp_w.push_back({a, blk[i+1]});
        end
        exp_count = nw;
        if (nd > int'(ml))
            exp_err = 3;
`ifdef TAPE_LOADER_CHECKSUM_EN
        else if (x != 8'd0)
            exp_err = 3;
`endif
        else
            exp_err = 0;
    endtask

    task automatic run_block(input logic [AW-1:0] base, input logic [AW-1:0] ml,
                             input int gap, input string name);
        int w0, v0, n;
        w0 = wr_log.size();
        v0 = stab_viol;
        model_block(base, ml);
        arm_and_sync(base, ml);
        base_addr = ~base;
        max_len   = ~ml;
        tests++;
        if (reader_start !== 1'b1) begin
            fails++;
            $display("FAIL %s reader_start first RECV: got %b want 1", name, reader_start);
        end
        tick();
        tests++;
        if (reader_start !== 1'b0) begin
            fails++;
            $display("FAIL %s reader_start second cycle: got %b want 0", name, reader_start);
        end
        foreach (blk[i]) send_bits(blk[i], 8, gap);
        wait_end(TO + 30, n);
        tests++;
        if (exp_err == 0) begin
            if (done !== 1'b1 || error !== 1'b0) begin
                fails++;
                $display("FAIL %s outcome: done=%b error=%b code=%0d want done", name, done, error, err_code);
            end
        end else if (error !== 1'b1 || done !== 1'b0 || err_code !== 2'(exp_err)) begin
            fails++;
            $display("FAIL %s outcome: done=%b error=%b code=%0d want error code %0d",
                     name, done, error, err_code, exp_err);
        end
        tests++;
        if (flag_byte !== blk[0]) begin
            fails++;
            $display("FAIL %s flag_byte: got %h want %h", name, flag_byte, blk[0]);
        end
        tests++;
        if (byte_count !== AW'(exp_count)) begin
            fails++;
            $display("FAIL %s byte_count: got %0d want %0d", name, byte_count, exp_count);
        end
        tests++;
        if (wr_log.size() - w0 != exp_w.size()) begin
            fails++;
            $display("FAIL %s write count: got %0d want %0d", name, wr_log.size() - w0, exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                tests++;
                if (wr_log[w0+i] !== exp_w[i]) begin
                    fails++;
                    $display("FAIL %s write %0d: got %h want %h", name, i, wr_log[w0+i], exp_w[i]);
                end
            end
        end
        tests++;
        if (stab_viol != v0) begin
            fails++;
            $display("FAIL %s request stability: %0d changes while waiting for ack", name, stab_viol - v0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests++;
        if ({reader_start, mem_wr_req, mem_addr, mem_wdata, busy, done, error,
             err_code, flag_byte, byte_count} !== '0) begin
            fails++;
            $display("FAIL reset outputs: req=%b addr=%h busy=%b done=%b err=%b code=%0d flag=%h cnt=%0d",
                     mem_wr_req, mem_addr, busy, done, error, err_code, flag_byte, byte_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed_ok();
        int w0;
        w0 = wr_log.size();
        ack_delay = 0;
        blk = '{8'h00, 8'hAA, 8'h55, 8'hFF};
        run_block(16'h4000, 16'd100, 2, "directed_ok");
        tests++;
        if (done !== 1'b1 || byte_count !== 16'd3 || flag_byte !== 8'h00) begin
            fails++;
            $display("FAIL directed_ok final: done=%b cnt=%0d flag=%h want 1/3/00", done, byte_count, flag_byte);
        end
        tests++;
        if (wr_log.size() < w0 + 3 || wr_log[w0] !== 24'h4000AA || wr_log[w0+1] !== 24'h400155 ||
            wr_log[w0+2] !== 24'h4002FF) begin
            fails++;
            $display("FAIL directed_ok writes: %0d logged, want 4000=AA 4001=55 4002=FF", wr_log.size() - w0);
        end
        disarm();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL directed_ok disarm: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_bad_checksum();
        blk = '{8'h00, 8'hAA, 8'h55, 8'hFE};
        run_block(16'h4000, 16'd100, 2, "bad_checksum");
        tests++;
`ifdef TAPE_LOADER_CHECKSUM_EN
        if (error !== 1'b1 || err_code !== 2'd3) begin
            fails++;
            $display("FAIL bad_checksum: error=%b code=%0d want 1/3", error, err_code);
        end
`else
        if (done !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL bad_checksum: done=%b error=%b want 1/0", done, error);
        end
`endif
        disarm();
    endtask

    task automatic test_overrun();
        int w0;
        w0 = wr_log.size();
        ack_en = 1'b0;
        arm_and_sync(16'h0100, 16'd50);
        send_bits(8'h12, 8, 1);
        send_bits(8'h34, 8, 1);
        tests++;
        if (mem_wr_req !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 8'h34) begin
            fails++;
            $display("FAIL overrun request: req=%b addr=%h data=%h want 1/0100/34", mem_wr_req, mem_addr, mem_wdata);
        end
        send_bits(8'h56, 8, 1);
        tests++;
        if (error !== 1'b1 || err_code !== 2'd2 || mem_wr_req !== 1'b0) begin
            fails++;
            $display("FAIL overrun: error=%b code=%0d req=%b want 1/2/0", error, err_code, mem_wr_req);
        end
        tests++;
        if (byte_count !== '0 || wr_log.size() != w0) begin
            fails++;
            $display("FAIL overrun writes: cnt=%0d logged=%0d want 0/0", byte_count, wr_log.size() - w0);
        end
        ack_en = 1'b1;
        disarm();
    endtask

    task automatic test_partial();
        int n, w0;
        w0 = wr_log.size();
        ack_delay = 0;
        arm_and_sync(16'h0200, 16'd50);
        send_bits(8'h00, 8, 2);
        send_bits(8'hC3, 8, 2);
        send_bits(8'hA0, 4, 1);
        wait_end(TO + 30, n);
        tests++;
        if (error !== 1'b1 || err_code !== 2'd1) begin
            fails++;
            $display("FAIL partial: error=%b code=%0d want 1/1", error, err_code);
        end
        tests++;
        if (n + 1 < TO || n + 1 > TO + 2) begin
            fails++;
            $display("FAIL partial timeout: %0d cycles after last bit, want %0d..%0d", n + 1, TO, TO + 2);
        end
        tests++;
        if (byte_count !== 16'd1 || wr_log.size() != w0 + 1 || wr_log[w0] !== 24'h0200C3) begin
            fails++;
            $display("FAIL partial writes: cnt=%0d logged=%0d want 1 write 0200=C3", byte_count, wr_log.size() - w0);
        end
        disarm();
    endtask

    task automatic test_max_len();
        blk = '{8'h00, 8'h11, 8'h22, 8'h33};
        run_block(16'h0300, 16'd2, 1, "max_len");
        tests++;
        if (error !== 1'b1 || err_code !== 2'd3 || byte_count !== 16'd2) begin
            fails++;
            $display("FAIL max_len: error=%b code=%0d cnt=%0d want 1/3/2", error, err_code, byte_count);
        end
        disarm();
    endtask

    task automatic test_arm_drop();
        ack_en = 1'b0;
        arm_and_sync(16'h0400, 16'd50);
        send_bits(8'h00, 8, 1);
        send_bits(8'h77, 8, 1);
        tests++;
        if (mem_wr_req !== 1'b1) begin
            fails++;
            $display("FAIL arm_drop setup: req=%b want 1", mem_wr_req);
        end
        arm = 1'b0;
        tick();
        tests++;
        if (mem_wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0) begin
            fails++;
            $display("FAIL arm_drop: req=%b busy=%b done=%b err=%b code=%0d want all 0",
                     mem_wr_req, busy, done, error, err_code);
        end
        ack_en = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        ack_en = 1'b0;
        arm_and_sync(16'h0500, 16'd50);
        send_bits(8'h5A, 8, 1);
        send_bits(8'h66, 8, 1);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (mem_wr_req !== 1'b0 || busy !== 1'b0 || byte_count !== '0 || flag_byte !== 8'h00 ||
            mem_addr !== '0) begin
            fails++;
            $display("FAIL async_reset: req=%b busy=%b cnt=%0d flag=%h addr=%h want all 0",
                     mem_wr_req, busy, byte_count, flag_byte, mem_addr);
        end
        arm = 1'b0;
        tick();
        reset  = 1'b0;
        ack_en = 1'b1;
        tick();
    endtask

    task automatic test_no_byte();
        arm_and_sync(16'h0600, 16'd50);
        repeat (TO + 10) tick();
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL no_byte: busy=%b done=%b error=%b want 1/0/0", busy, done, error);
        end
        sync_detected = 1'b1;
        tick();
        sync_detected = 1'b0;
        tests++;
        if (reader_start !== 1'b1) begin
            fails++;
            $display("FAIL no_byte resync: reader_start=%b want 1", reader_start);
        end
        disarm();
    endtask

    task automatic test_ignore_bits();
        logic [AW-1:0] c0;
        base_addr = 16'h0700;
        arm = 1'b1;
        tick();
        send_bits(8'hFF, 5, 1);
        blk = '{8'h5A, 8'h11, 8'h4B};
        run_block(16'h0700, 16'd10, 1, "ignore_bits");
        c0 = byte_count;
        send_bits(8'hFF, 8, 1);
        tests++;
        if (done !== 1'b1 || byte_count !== c0 || flag_byte !== 8'h5A) begin
            fails++;
            $display("FAIL ignore_bits after done: done=%b cnt=%0d flag=%h want 1/%0d/5A", done, byte_count, flag_byte, c0);
        end
        disarm();
    endtask

    task automatic test_random();
        int            nd, gap;
        logic [7:0]    x;
        logic [AW-1:0] base, ml;
        for (int it = 0; it < 16; it++) begin
            nd = $urandom_range(1, 5);
            blk.delete();
            for (int k = 0; k <= nd; k++) blk.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                x = 8'd0;
                for (int k = 0; k < nd; k++) x ^= blk[k];
                blk[nd] = x;
            end
            base      = ($urandom_range(0, 2) == 0) ? 16'hFFFE : AW'($urandom);
            ml        = AW'($urandom_range(0, 6));
            gap       = $urandom_range(1, 3);
            ack_delay = $urandom_range(0, 4);
            run_block(base, ml, gap, "random");
            disarm();
        end
        ack_delay = 0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; sync_detected = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
        base_addr = '0; max_len = '0;
        test_reset();
        test_directed_ok();
        test_bad_checksum();
        test_overrun();
        test_partial();
        test_max_len();
        test_arm_drop();
        test_async_reset();
        test_no_byte();
        test_ignore_bits();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tape_block_loader.md
TAPE_BLOCK_LOADER -- requirements
Module: tape_block_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 54000, meaning clk cycles without bit_valid that end a block (~2 ms at 27 MHz).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning memory address width.
REQ-003 SHALL have these ports:
- clk  in  1  system clock; one clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  level; high enables loading, low aborts.
- sync_detected  in  1  1-cycle pulse; pilot/sync seen.
- bit_valid  in  1  1-cycle pulse; new bit from bit reader.
- bit_data  in  1  bit value, qualified by bit_valid.
- base_addr  in  ADDR_W  first write address, sampled on leaving IDLE.
- max_len  in  ADDR_W  maximum data bytes, sampled on leaving IDLE.
- reader_start  out  1  1-cycle pulse that starts the bit reader.
- mem_wr_req  out  1  write request, held until ack.
- mem_wr_ack  in  1  write accepted.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- busy  out  1  high in any state other than IDLE, DONE, ERROR.
- done  out  1  level; block loaded.
- error  out  1  level; load failed.
- err_code  out  2  0 none, 1 partial byte, 2 overrun, 3 length/checksum.
- flag_byte  out  8  first received byte.
- byte_count  out  ADDR_W  data bytes written.

Function
REQ-004 SHALL implement states IDLE, WAIT_SYNC, RECV, WRITE, CHECK, DONE, ERROR.
REQ-005 IDLE -> WAIT_SYNC when arm=1; base_addr and max_len latched; byte_count, checksum, bit counter cleared.
REQ-006 WAIT_SYNC -> RECV on sync_detected; reader_start pulses high for exactly the first RECV cycle.
REQ-007 Bits SHALL be shifted in MSB-first on bit_valid in RECV and WRITE; the 8th bit completes a byte.
REQ-008 Every completed byte SHALL be XORed into an 8-bit running checksum.
REQ-009 First completed byte SHALL be latched into flag_byte and not written to memory.
REQ-010 Each subsequent byte SHALL enter WRITE on the next cycle: mem_wr_req=1, mem_addr=base_addr+byte_count, mem_wdata=byte.
REQ-011 In WRITE, mem_wr_req, mem_addr and mem_wdata SHALL stay stable until the cycle with mem_wr_ack=1; on the next cycle mem_wr_req=0, byte_count+1, state returns to RECV.
REQ-012 A byte completing while in WRITE SHALL force ERROR with err_code=2 (overrun); the pending request is dropped.
REQ-013 A data byte completing when byte_count==max_len SHALL force ERROR with err_code=3; no write is issued.
REQ-014 The timeout counter SHALL clear on every bit_valid and on entry to RECV, and count in RECV only; reaching TIMEOUT_TICKS-1 -> CHECK.
REQ-015 CHECK SHALL go to ERROR with err_code=1 if the bit counter is nonzero (partial byte); if no byte was received, it returns to WAIT_SYNC.
REQ-016 Otherwise, CHECK SHALL go to DONE when the checksum equals 0 and ERROR with err_code=3 when it does not; the decision takes one cycle.
REQ-017 DONE and ERROR SHALL hold until arm=0, then go to IDLE; done and error are exclusive.
REQ-018 arm=0 in any state SHALL return to IDLE next cycle, with mem_wr_req dropped and done, error and err_code cleared.
REQ-019 byte_count and mem_addr SHALL wrap modulo 2^ADDR_W.
REQ-020 bit_valid in IDLE, WAIT_SYNC, CHECK, DONE and ERROR SHALL be ignored.

Reset
REQ-021 With reset high, the block SHALL be in state IDLE and all outputs SHALL be 0, including flag_byte, byte_count and err_code.
REQ-022 Reset mid-transfer SHALL drop mem_wr_req immediately (asynchronously); the partial block is discarded.

Configuration
REQ-023 Macro TAPE_LOADER_CHECKSUM_EN SHALL control checksum checking.
- Defined: REQ-008 and REQ-016 apply.
- Undefined: no checksum register; CHECK with no partial byte always goes to DONE.

Verification
REQ-024 Directed scenario: arm=1, sync, bytes 0x00,0xAA,0x55,0xFF, all acks 1 cycle later, base_addr=0x4000 -> writes 0x4000=AA, 0x4001=55, 0x4002=FF; flag_byte=00; after timeout done=1, byte_count=3.
REQ-025 Directed scenario: same bytes with last byte 0xFE -> error=1, err_code=3 when TAPE_LOADER_CHECKSUM_EN is defined; done=1 when it is undefined.
REQ-026 Directed scenario: ack withheld while 8 further bits arrive -> error=1, err_code=2, mem_wr_req=0.
REQ-027 Directed scenario: flag byte plus 12 bits, then silence -> error=1, err_code=1 after TIMEOUT_TICKS cycles.
REQ-028 Directed scenario: max_len=2 with 3 data bytes -> exactly 2 writes, error=1, err_code=3.
REQ-029 Directed scenario: arm dropped while mem_wr_req=1 -> next cycle IDLE, mem_wr_req=0, busy=0.
